// File: rtl/bit_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bit_stream_pkg
// Description : Shared width default and state encoding for the bit-stream
//               deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
package bit_stream_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

endpackage : bit_stream_pkg
`default_nettype wire

// File: rtl/bit_stream_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : bit_stream_deserializer
// Description : Collects serial bits MSB-first into WIDTH-bit words; emits a
//               full word or a flushed, left-aligned partial word.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_stream_deserializer
  import bit_stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    srst_i,
  input  logic                    data_i,
  input  logic                    data_val_i,
  input  logic                    flush_i,
  output logic [WIDTH-1:0]        deser_data_o,
  output logic [$clog2(WIDTH):0]  deser_len_o,
  output logic                    deser_data_val_o,
  output logic                    busy_o
);

  localparam int                CW         = $clog2(WIDTH);
  localparam int                LW         = CW + 1;
  localparam logic [CW-1:0]     C_CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  C_MSB      = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_shift;

  logic [WIDTH-1:0]   r_data;
  logic [LW-1:0]      r_len;
  logic               r_data_val;
  logic               r_busy;

  state_t             w_state_nxt;
  logic [CW-1:0]      w_cnt_nxt;
  logic [WIDTH-1:0]   w_shift_nxt;
  logic [WIDTH-1:0]   w_shift_acc;
  logic [WIDTH-1:0]   w_bit_mask;
  logic [LW-1:0]      w_len_post;
  logic               w_emit;

  // State register: counter, shift register and FSM state move together.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Each bit is written straight into its final MSB-first slot, so the word is
  // already left-aligned and the unwritten low bits stay zero.
  always_comb begin
    w_bit_mask  = C_MSB >> r_cnt;
    w_shift_acc = r_shift;
    if (data_val_i) begin
      w_shift_acc = data_i ? (r_shift | w_bit_mask) : (r_shift & ~w_bit_mask);
    end
    w_cnt_nxt   = w_emit ? '0 : (r_cnt + CW'(data_val_i));
    w_shift_nxt = w_emit ? '0 : w_shift_acc;
    w_state_nxt = (w_cnt_nxt != '0) ? FILL : IDLE;
  end

  // The post-acceptance count includes a bit arriving alongside flush_i.
  always_comb begin
    w_len_post = LW'(r_cnt) + LW'(data_val_i);
    w_emit     = (data_val_i && (r_cnt == C_CNT_LAST)) ||
                 (flush_i && ((r_state == FILL) || data_val_i));
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_data     <= '0;
      r_len      <= '0;
      r_data_val <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_data_val <= w_emit;
      r_busy     <= (w_state_nxt == FILL);
      if (w_emit) begin
        r_data <= w_shift_acc;
        r_len  <= w_len_post;
      end
    end
  end

  assign deser_data_o     = r_data;
  assign deser_len_o      = r_len;
  assign deser_data_val_o = r_data_val;
  assign busy_o           = r_busy;

endmodule : bit_stream_deserializer
`default_nettype wire

// File: tb/tb_bit_stream_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_stream_deserializer
// Description : Directed table for WIDTH=8 plus model-checked random streams
//               for WIDTH=32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_stream_deserializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       s8_srst, s8_din, s8_val, s8_flush;
  logic [7:0] d8_data;
  logic [3:0] d8_len;
  logic       d8_val, d8_busy;

  logic        s32_srst, s32_din, s32_val, s32_flush;
  logic [31:0] d32_data;
  logic [5:0]  d32_len;
  logic        d32_val, d32_busy;

  bit_stream_deserializer #(.WIDTH(8)) u_dut8 (
    .clk_i            (clk),
    .srst_i           (s8_srst),
    .data_i           (s8_din),
    .data_val_i       (s8_val),
    .flush_i          (s8_flush),
    .deser_data_o     (d8_data),
    .deser_len_o      (d8_len),
    .deser_data_val_o (d8_val),
    .busy_o           (d8_busy)
  );

  bit_stream_deserializer #(.WIDTH(32)) u_dut32 (
    .clk_i            (clk),
    .srst_i           (s32_srst),
    .data_i           (s32_din),
    .data_val_i       (s32_val),
    .flush_i          (s32_flush),
    .deser_data_o     (d32_data),
    .deser_len_o      (d32_len),
    .deser_data_val_o (d32_val),
    .busy_o           (d32_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       srst, val, din, flush;
    logic       e_val;
    logic [7:0] e_data;
    logic [3:0] e_len;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic srst, input logic val, input logic din,
                              input logic flush, input logic e_val,
                              input logic [7:0] e_data, input logic [3:0] e_len,
                              input logic e_busy);
    vec_t v;
    v.srst = srst; v.val = val; v.din = din; v.flush = flush;
    v.e_val = e_val; v.e_data = e_data; v.e_len = e_len; v.e_busy = e_busy;
    return v;
  endfunction

  // Reference for the 32-bit stream: explicit bit index into the word.
  int          m_cnt = 0;
  logic [31:0] m_word = '0;
  logic [31:0] m_last_data = '0;
  logic [5:0]  m_last_len = '0;
  int          dut_pulses = 0;

  task automatic step32(input logic v, input logic d, input logic f);
    logic exp_pulse;
    logic had_bits;
    @(negedge clk);
    s32_val = v; s32_din = d; s32_flush = f;
    @(posedge clk);
    #1;
    had_bits = (m_cnt != 0) || v;
    if (v) begin
      m_word[31 - m_cnt] = d;
      m_cnt++;
    end
    exp_pulse = (m_cnt == 32) || (f && had_bits);
    if (exp_pulse) begin
      m_last_data = m_word;
      m_last_len  = 6'(m_cnt);
      m_cnt  = 0;
      m_word = '0;
    end
    if (d32_val === 1'b1) dut_pulses++;
    check("w32_val",  {63'd0, d32_val}, {63'd0, exp_pulse});
    check("w32_data", {32'd0, d32_data}, {32'd0, m_last_data});
    check("w32_len",  {58'd0, d32_len}, {58'd0, m_last_len});
    check("w32_busy", {63'd0, d32_busy}, {63'd0, (m_cnt != 0)});
  endtask

  initial begin
    int accepted;
    int cycles;
    int p0;

    s8_srst = 1'b0; s8_din = 1'b0; s8_val = 1'b0; s8_flush = 1'b0;
    s32_srst = 1'b1; s32_din = 1'b0; s32_val = 1'b0; s32_flush = 1'b0;

    // srst val din flush | e_val e_data e_len e_busy
    vecs.push_back(mk(1,0,0,0, 0,8'h00,4'd0,0));
    // 1,0,1,1,0,0,0,1 -> B1
    vecs.push_back(mk(0,1,1,0, 0,8'h00,4'd0,1));
    vecs.push_back(mk(0,1,0,0, 0,8'h00,4'd0,1));
    vecs.push_back(mk(0,1,1,0, 0,8'h00,4'd0,1));
    vecs.push_back(mk(0,1,1,0, 0,8'h00,4'd0,1));
    vecs.push_back(mk(0,1,0,0, 0,8'h00,4'd0,1));
    vecs.push_back(mk(0,1,0,0, 0,8'h00,4'd0,1));
    vecs.push_back(mk(0,1,0,0, 0,8'h00,4'd0,1));
    vecs.push_back(mk(0,1,1,0, 1,8'hB1,4'd8,0));
    vecs.push_back(mk(0,0,0,0, 0,8'hB1,4'd8,0));
    // 1,1,1 then flush -> E0 / 3
    vecs.push_back(mk(0,1,1,0, 0,8'hB1,4'd8,1));
    vecs.push_back(mk(0,1,1,0, 0,8'hB1,4'd8,1));
    vecs.push_back(mk(0,1,1,0, 0,8'hB1,4'd8,1));
    vecs.push_back(mk(0,0,0,1, 1,8'hE0,4'd3,0));
    vecs.push_back(mk(0,0,0,0, 0,8'hE0,4'd3,0));
    // seven 1s, then 0 with flush -> one FE / 8 pulse; empty flush is silent
    for (int i = 0; i < 7; i++) vecs.push_back(mk(0,1,1,0, 0,8'hE0,4'd3,1));
    vecs.push_back(mk(0,1,0,1, 1,8'hFE,4'd8,0));
    vecs.push_back(mk(0,0,0,1, 0,8'hFE,4'd8,0));
    vecs.push_back(mk(0,0,0,0, 0,8'hFE,4'd8,0));
    // 1,0,1,0, reset, eight 1s -> only FF
    vecs.push_back(mk(0,1,1,0, 0,8'hFE,4'd8,1));
    vecs.push_back(mk(0,1,0,0, 0,8'hFE,4'd8,1));
    vecs.push_back(mk(0,1,1,0, 0,8'hFE,4'd8,1));
    vecs.push_back(mk(0,1,0,0, 0,8'hFE,4'd8,1));
    vecs.push_back(mk(1,0,0,0, 0,8'h00,4'd0,0));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(0,1,1,0, 0,8'h00,4'd0,1));
    vecs.push_back(mk(0,1,1,0, 1,8'hFF,4'd8,0));
    vecs.push_back(mk(0,0,0,0, 0,8'hFF,4'd8,0));
    // bit accepted with flush counts: 1 then 0+flush -> 80 / 2
    vecs.push_back(mk(0,1,1,0, 0,8'hFF,4'd8,1));
    vecs.push_back(mk(0,1,0,1, 1,8'h80,4'd2,0));
    // gaps hold state: 1, gap, gap, 1+flush -> C0 / 2
    vecs.push_back(mk(0,1,1,0, 0,8'h80,4'd2,1));
    vecs.push_back(mk(0,0,0,0, 0,8'h80,4'd2,1));
    vecs.push_back(mk(0,0,1,0, 0,8'h80,4'd2,1));
    vecs.push_back(mk(0,1,1,1, 1,8'hC0,4'd2,0));
    // reset beats data and flush in the same cycle
    vecs.push_back(mk(0,1,1,0, 0,8'hC0,4'd2,1));
    vecs.push_back(mk(1,1,1,1, 0,8'h00,4'd0,0));
    vecs.push_back(mk(0,0,0,1, 0,8'h00,4'd0,0));
    // completion followed immediately by next word's first bit
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0,1,i[0],0, (i == 7),
                                                  (i == 7) ? 8'h55 : 8'h00,
                                                  (i == 7) ? 4'd8 : 4'd0, (i != 7)));
    vecs.push_back(mk(0,1,1,1, 1,8'h80,4'd1,0));

    foreach (vecs[i]) begin
      @(negedge clk);
      s8_srst = vecs[i].srst; s8_val = vecs[i].val;
      s8_din = vecs[i].din;   s8_flush = vecs[i].flush;
      @(posedge clk);
      #1;
      check($sformatf("w8_val[%0d]", i),  {63'd0, d8_val},  {63'd0, vecs[i].e_val});
      check($sformatf("w8_data[%0d]", i), {56'd0, d8_data}, {56'd0, vecs[i].e_data});
      check($sformatf("w8_len[%0d]", i),  {60'd0, d8_len},  {60'd0, vecs[i].e_len});
      check($sformatf("w8_busy[%0d]", i), {63'd0, d8_busy}, {63'd0, vecs[i].e_busy});
      if (i == 1) s32_srst = 1'b0;
    end
    @(negedge clk);
    s8_val = 1'b0; s8_flush = 1'b0;

    check("w32_rst_data", {32'd0, d32_data}, 64'd0);
    check("w32_rst_busy", {63'd0, d32_busy}, 64'd0);

    // 64 random bits with ~50% valid duty
    p0 = dut_pulses;
    accepted = 0;
    cycles = 0;
    while (accepted < 64 && cycles < 1000) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      step32(v, 1'($urandom_range(0, 1)), 1'b0);
      if (v) accepted++;
      cycles++;
    end
    check("w32_gap_pulses", 64'(dut_pulses - p0), 64'd2);
    check("w32_gap_busy", {63'd0, d32_busy}, 64'd0);

    // 200 back-to-back bits -> 6 words, 8 bits left over
    p0 = dut_pulses;
    for (int i = 0; i < 200; i++) step32(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    check("w32_b2b_pulses", 64'(dut_pulses - p0), 64'd6);
    check("w32_b2b_busy", {63'd0, d32_busy}, 64'd1);
    step32(1'b0, 1'b0, 1'b1);
    check("w32_tail_len", {58'd0, d32_len}, 64'd8);
    step32(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_bit_stream_deserializer
`default_nettype wire

// File: doc/bit_stream_deserializer.md
BIT_STREAM_DESERIALIZER -- requirements
Module: bit_stream_deserializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the output word width in bits; legal values are 2..64.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock, rising edge active.
REQ-003 The block SHALL have port srst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port data_i, input, 1 bit: serial data bit.
REQ-005 The block SHALL have port data_val_i, input, 1 bit: data_i is valid this cycle.
REQ-006 The block SHALL have port flush_i, input, 1 bit: emit the partially collected word.
REQ-007 The block SHALL have port deser_data_o, output, WIDTH bits: collected word, MSB-first, suitable for direct connection to a WIDTH-bit popcount stage.
REQ-008 The block SHALL have port deser_len_o, output, $clog2(WIDTH)+1 bits: number of valid bits in deser_data_o.
REQ-009 The block SHALL have port deser_data_val_o, output, 1 bit: one-cycle pulse marking deser_data_o and deser_len_o valid.
REQ-010 The block SHALL have port busy_o, output, 1 bit: a partial word is held (bit count > 0).

Function
REQ-011 Each cycle with data_val_i=1, the block SHALL accept data_i; no back-pressure exists.
REQ-012 The first accepted bit of a word SHALL appear at deser_data_o[WIDTH-1], the k-th at deser_data_o[WIDTH-k].
REQ-013 The block SHALL keep an internal bit counter cnt in the range 0..WIDTH-1: 0 is the IDLE state, 1..WIDTH-1 is the FILL state.
REQ-014 Acceptance of the WIDTH-th bit SHALL produce, on the next rising edge, deser_data_val_o=1, the full word, and deser_len_o=WIDTH; cnt SHALL return to 0 on that same edge.
REQ-015 Latency SHALL be exactly 1 cycle from the accepting edge of the last bit to the output valid pulse.
REQ-016 flush_i=1 with a post-acceptance count n in 1..WIDTH-1 SHALL emit on the next edge: the n bits left-aligned, lower WIDTH-n bits zero, deser_len_o=n, deser_data_val_o=1; cnt SHALL become 0.
REQ-017 The count n SHALL include a bit accepted in the same cycle as flush_i.
REQ-018 flush_i=1 with n=0 SHALL produce no pulse.
REQ-019 flush_i=1 in the same cycle as the WIDTH-th bit SHALL produce exactly one full-word pulse (len=WIDTH); the following word SHALL start empty.
REQ-020 A new word's bits SHALL be accepted back-to-back in the cycle immediately after a completion or flush, with no gap cycle.
REQ-021 data_val_i=0 cycles SHALL leave cnt and the collected bits unchanged; gaps of any length are legal.
REQ-022 deser_data_val_o SHALL be high for exactly one cycle per emitted word.
REQ-023 deser_data_o and deser_len_o SHALL hold the last emitted values while deser_data_val_o=0.
REQ-024 busy_o SHALL be registered and equal (cnt != 0) after each edge.
REQ-025 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-026 While srst_i=1, at each edge, the block SHALL clear cnt, the shift register, deser_data_o, and deser_len_o to 0, and set deser_data_val_o=0 and busy_o=0.
REQ-027 srst_i SHALL take priority over data_val_i and flush_i; a partial word at reset SHALL be discarded with no pulse.
REQ-028 The first valid bit accepted after srst_i falls SHALL be bit 1 of a new word.

Structure
REQ-029 A shared package bit_stream_pkg SHALL hold the DEFAULT_WIDTH=32 constant and the state enum (IDLE, FILL).
REQ-030 The block SHALL contain no sub-modules: one shift register, one counter, and one output register stage.
REQ-031 A separate top-level block SHALL connect deser_data_o and deser_data_val_o to the popcount stage's data_i and data_val_i; that top level is outside this block's scope.

Verification
REQ-032 Scenario, WIDTH=8: bits 1,0,1,1,0,0,0,1 on consecutive cycles -> next cycle deser_data_o=8'hB1, deser_len_o=8, single-cycle pulse.
REQ-033 Scenario, WIDTH=8: bits 1,1,1 then flush_i alone -> deser_data_o=8'hE0, deser_len_o=3; busy_o is 1 before the flush and 0 after.
REQ-034 Scenario, WIDTH=8: 7 bits all 1, then 8th bit 0 with flush_i=1 in the same cycle -> exactly one pulse with 8'hFE, len=8; a following flush with no bits gives no pulse.
REQ-035 Scenario, WIDTH=8: 4 bits 1,0,1,0, srst_i for 1 cycle, then 8 bits of 1 -> no pulse for the pre-reset bits; a single pulse with 8'hFF.
REQ-036 Scenario, WIDTH=32: 64 random bits with random data_val_i gaps (50% duty) -> two pulses whose words match a reference model bit-for-bit.
REQ-037 Scenario, WIDTH=32: 200 random valid bits with no gaps -> 6 back-to-back word pulses with no dropped or duplicated bits; busy_o=1 at the end with 8 bits held.
